// File: rtl/mem_line_cache.sv
// Direct-mapped write-through read cache on one MCB port; read hit 1 cycle, write 3 cycles, cmd issue stalls on cmd_full.
// MEM_WRITE_FLUSH_EN: writes also wait for wr_empty before ack; req is ignored while busy (no queueing).
module mem_line_cache #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 18,
    parameter int LINES      = 4,
    parameter int LINE_WORDS = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                calib_done,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                busy,
    output logic                err,
    output logic                cmd_en,
    output logic [2:0]          cmd_instr,
    output logic [5:0]          cmd_bl,
    output logic [29:0]         cmd_byte_addr,
    input  logic                cmd_full,
    output logic                wr_en,
    output logic [DATA_W/8-1:0] wr_mask,
    output logic [DATA_W-1:0]   wr_data,
    input  logic                wr_full,
    input  logic                wr_empty,
    output logic                rd_en,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_empty
);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int LOG_LW  = $clog2(LINE_WORDS);
    localparam int LOG_LN  = $clog2(LINES);
    localparam int OFF_W   = (LOG_LW > 0) ? LOG_LW : 1;
    localparam int IDX_W   = (LOG_LN > 0) ? LOG_LN : 1;
    localparam int TAG_W   = ADDR_W - LOG_LW - LOG_LN;
    localparam int TMO_W   = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_CMD  = 3'd3,
        S_RD_CMD  = 3'd4,
        S_RD_FILL = 3'd5,
        S_DONE    = 3'd6
`ifdef MEM_WRITE_FLUSH_EN
        , S_WR_DRAIN = 3'd7
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [OFF_W-1:0]    k_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                err_q;
    logic                tout_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES][LINE_WORDS];

    function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] a);
        return OFF_W'(a & ADDR_W'(LINE_WORDS - 1));
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'((a >> LOG_LW) & ADDR_W'(LINES - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [29:0] byte_addr(input logic [ADDR_W-1:0] a);
        return 30'(a) << BYTE_SH;
    endfunction

    logic req_hit, accept, cmd_fire, word_acc, last_word, tmo_hit;

    always_comb begin
        req_hit   = valid_q[idx_of(addr)] && (tag_mem[idx_of(addr)] == tag_of(addr));
        accept    = (state_q == S_IDLE) && req;
        cmd_fire  = ((state_q == S_WR_CMD) || (state_q == S_RD_CMD)) && !cmd_full;
        word_acc  = (state_q == S_RD_FILL) && !rd_empty;
        last_word = word_acc && (k_q == OFF_W'(LINE_WORDS - 1));
        tmo_hit   = (state_q == S_RD_FILL) && rd_empty && (tmo_q == TMO_W'(RD_TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    if (calib_done) state_d = S_IDLE;
            S_IDLE:    if (req) state_d = we ? S_WR_DATA : (req_hit ? S_DONE : S_RD_CMD);
            S_WR_DATA: state_d = S_WR_CMD;
`ifdef MEM_WRITE_FLUSH_EN
            S_WR_CMD:   if (!cmd_full) state_d = S_WR_DRAIN;
            S_WR_DRAIN: if (wr_empty) state_d = S_DONE;
`else
            S_WR_CMD:  if (!cmd_full) state_d = S_DONE;
`endif
            S_RD_CMD:  if (!cmd_full) state_d = S_RD_FILL;
            S_RD_FILL: if (last_word || tmo_hit) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    always_comb begin
        busy          = (state_q != S_IDLE);
        ack           = 1'b0;
        rdata         = '0;
        cmd_en        = cmd_fire;
        cmd_instr     = 3'd0;
        cmd_bl        = 6'd0;
        cmd_byte_addr = 30'd0;
        wr_en         = 1'b0;
        wr_data       = '0;
        rd_en         = word_acc;
        case (state_q)
            S_WR_DATA: begin
                wr_en   = 1'b1;
                wr_data = wdata_q;
            end
            S_WR_CMD:  cmd_byte_addr = byte_addr(addr_q);
            S_RD_CMD: begin
                cmd_instr     = 3'd1;
                cmd_bl        = 6'(LINE_WORDS - 1);
                cmd_byte_addr = byte_addr(addr_q & ~ADDR_W'(LINE_WORDS - 1));
            end
            S_DONE: begin
                ack = 1'b1;
                if (tout_q)    rdata = '0;
                else if (we_q) rdata = wdata_q;
                else           rdata = data_mem[idx_of(addr_q)][off_of(addr_q)];
            end
            default: ;
        endcase
    end

    assign err     = err_q;
    assign wr_mask = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            k_q     <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
                tout_q  <= 1'b0;
            end
            // The line is invalid for the whole fill so a timeout leaves no stale half-line behind.
            if (cmd_fire && (state_q == S_RD_CMD)) begin
                valid_q[idx_of(addr_q)] <= 1'b0;
                k_q   <= '0;
                tmo_q <= '0;
            end
            if (word_acc) begin
                k_q   <= k_q + 1'b1;
                tmo_q <= '0;
            end else if (state_q == S_RD_FILL) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (last_word) valid_q[idx_of(addr_q)] <= 1'b1;
            if (tmo_hit) begin
                err_q  <= 1'b1;
                tout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && we && req_hit) data_mem[idx_of(addr)][off_of(addr)] <= wdata;
        if (word_acc)  data_mem[idx_of(addr_q)][k_q] <= rd_data;
        if (last_word) tag_mem[idx_of(addr_q)] <= tag_of(addr_q);
    end

`ifdef MEM_WRITE_FLUSH_EN
    logic unused_in;
    assign unused_in = wr_full;
`else
    logic unused_in;
    assign unused_in = wr_full ^ wr_empty;
`endif

endmodule
